// File: rtl/cfu_requant_pack.sv
// Requantize int32 accumulators to int8 (bias add, SRDHM, rounding shift, offset, clamp)
// and pack four results little-endian into 32-bit words for write-back.
module cfu_requant_pack #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_acc,
  input  logic [31:0]        in_bias,
  input  logic [31:0]        in_mult,
  input  logic [5:0]         in_shift,
  input  logic               in_last,
  input  logic [8:0]         cfg_out_offset,
  input  logic [7:0]         cfg_act_min,
  input  logic [7:0]         cfg_act_max,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [2:0]         out_lanes
);

  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;
  localparam logic signed [63:0] TRUNC_BIAS = 64'sd2147483647;

  // Handshake: a sample transfers on in_valid && in_ready; a word transfers on
  // out_valid && out_ready. The whole pipeline advances together on en, and only a
  // held output word that the consumer has not taken freezes it.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Stage 1: bias add and optional left shift
  logic        shift_pos;
  logic [5:0]  neg_shift;
  logic [4:0]  rsh_in;
  logic [31:0] sum_in;
  logic [31:0] sum_shifted;

  assign shift_pos   = !in_shift[5] && (in_shift != 6'd0);
  assign neg_shift   = -in_shift;
  assign rsh_in      = in_shift[5] ? neg_shift[4:0] : 5'd0;
  assign sum_in      = in_acc + in_bias;
  assign sum_shifted = shift_pos ? (sum_in << in_shift[4:0]) : sum_in;

  logic        s1_valid;
  logic [31:0] s1_s;
  logic [31:0] s1_mult;
  logic [4:0]  s1_rsh;
  logic        s1_last;

  // Stage 2: saturating rounding doubling high multiply
  logic signed [63:0] s_ext;
  logic signed [63:0] m_ext;
  logic signed [63:0] prod;
  logic signed [63:0] prod_nudged;
  logic signed [63:0] prod_biased;
  logic signed [63:0] h_wide;
  logic               both_min;
  logic [31:0]        h_next;

  assign s_ext       = {{32{s1_s[31]}}, s1_s};
  assign m_ext       = {{32{s1_mult[31]}}, s1_mult};
  assign prod        = s_ext * m_ext;
  assign prod_nudged = prod + (prod[63] ? NUDGE_NEG : NUDGE_POS);
  // Arithmetic shift floors; pre-biasing negatives makes it truncate toward zero.
  assign prod_biased = prod_nudged + (prod_nudged[63] ? TRUNC_BIAS : 64'sd0);
  assign h_wide      = prod_biased >>> 31;
  assign both_min    = (s1_s == 32'h8000_0000) && (s1_mult == 32'h8000_0000);
  assign h_next      = both_min ? 32'h7FFF_FFFF : h_wide[31:0];

  logic        s2_valid;
  logic [31:0] s2_h;
  logic [4:0]  s2_rsh;
  logic        s2_last;

  // Stage 3: rounding divide by power of two, output offset, activation clamp
  logic [31:0]        rdiv_mask;
  logic [31:0]        rdiv_rem;
  logic [31:0]        rdiv_thr;
  logic signed [31:0] h_sra;
  logic [31:0]        q;
  logic signed [32:0] y;
  logic signed [32:0] y_clamped;
  logic signed [32:0] act_min_ext;
  logic signed [32:0] act_max_ext;

  assign rdiv_mask   = (32'd1 << s2_rsh) - 32'd1;
  assign rdiv_rem    = s2_h & rdiv_mask;
  assign rdiv_thr    = (rdiv_mask >> 1) + {31'd0, s2_h[31]};
  assign h_sra       = $signed(s2_h) >>> s2_rsh;
  assign q           = h_sra + {31'd0, (rdiv_rem > rdiv_thr)};
  assign y           = {q[31], q} + {{24{cfg_out_offset[8]}}, cfg_out_offset};
  assign act_min_ext = {{25{cfg_act_min[7]}}, cfg_act_min};
  assign act_max_ext = {{25{cfg_act_max[7]}}, cfg_act_max};

  always_comb begin
    y_clamped = y;
    if (y < act_min_ext) y_clamped = act_min_ext;
    if (y > act_max_ext) y_clamped = act_max_ext;
  end

  logic       s3_valid;
  logic [7:0] s3_y;
  logic       s3_last;

  // Packer: lanes above lane_cnt in pack_buf are always zero
  logic [1:0]         lane_cnt;
  logic [8*LANES-1:0] pack_buf;
  logic [8*LANES-1:0] pack_next;
  logic               emit;

  always_comb begin
    pack_next = pack_buf;
    for (int k = 0; k < LANES; k++) begin
      if (lane_cnt == 2'(k)) pack_next[8*k +: 8] = s3_y;
    end
  end

  assign emit = s3_valid && ((lane_cnt == 2'(LANES - 1)) || s3_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      lane_cnt  <= 2'd0;
      pack_buf  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lanes <= 3'd0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= emit;
      if (s3_valid) begin
        if (emit) begin
          out_data  <= pack_next;
          out_lanes <= {1'b0, lane_cnt} + 3'd1;
          lane_cnt  <= 2'd0;
          pack_buf  <= '0;
        end else begin
          pack_buf <= pack_next;
          lane_cnt <= lane_cnt + 2'd1;
        end
      end
    end
  end

  // Datapath registers carry no reset; their valids gate every use.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_s    <= sum_shifted;
      s1_mult <= in_mult;
      s1_rsh  <= rsh_in;
      s1_last <= in_last;
      s2_h    <= h_next;
      s2_rsh  <= s1_rsh;
      s2_last <= s1_last;
      s3_y    <= y_clamped[7:0];
      s3_last <= s2_last;
    end
  end

endmodule
